// File: rtl/dist_filter.sv
// dist_filter: validates 12-bit cm distance samples from the ranging stage,
// smooths them with a 2^LOG2_WIN moving average, and drives a hysteretic
// proximity alarm plus an echo-loss watchdog.
// Optional build macro DIST_MEDIAN3_EN inserts a median-of-3 stage ahead of
// the averager, which raises strobe-to-avg_valid latency from 2 to 3 cycles.
module dist_filter #(
    parameter int LOG2_WIN    = 2,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int NEAR_CM     = 20,
    parameter int HYST_CM     = 5,
    parameter int TIMEOUT_CYC = 20_000_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [11:0] dist_in,
    input  logic        dist_valid,
    output logic [11:0] avg_out,
    output logic        avg_valid,
    output logic        near,
    output logic        no_echo,
    output logic        reject
);
    localparam int WIN   = 1 << LOG2_WIN;
    localparam int SUM_W = 12 + LOG2_WIN;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [11:0]      MIN_V    = 12'(MIN_CM);
    localparam logic [11:0]      MAX_V    = 12'(MAX_CM);
    localparam logic [11:0]      NEAR_V   = 12'(NEAR_CM);
    localparam logic [11:0]      REL_V    = 12'(NEAR_CM + HYST_CM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next;
    logic                  in_range_s;
    logic                  accept_s;
    logic                  timeout_s;
    logic                  s1_valid_r;
    logic [11:0]           s1_data_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  a_valid_s;
    logic [11:0]           a_data_s;
    logic [11:0]           buf_r [WIN];
    logic [LOG2_WIN-1:0]   wptr_r;
    logic [SUM_W-1:0]      sum_r;
    logic [SUM_W-1:0]      sum_next;
    logic [11:0]           avg_next;
    logic                  near_next;

    assign in_range_s = (dist_in >= MIN_V) && (dist_in <= MAX_V);
    assign accept_s   = dist_valid && in_range_s;
    // A fresh accepted sample in the expiry cycle cancels the timeout.
    assign timeout_s  = !accept_s && (cnt_r == CNT_LAST);

    // Input stage: latch accepted samples, pulse reject for out-of-range strobes.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 12'd0;
            reject     <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            reject     <= dist_valid && !in_range_s;
            if (accept_s) begin
                s1_data_r <= dist_in;
            end else begin
                s1_data_r <= s1_data_r;
            end
        end
    end

    // Watchdog: cycles since the last accepted sample, saturating at expiry.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_LAST) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef DIST_MEDIAN3_EN
    logic [11:0] hist0_r;
    logic [11:0] hist1_r;
    logic        med_empty_r;
    logic        m_valid_r;
    logic [11:0] m_data_r;

    function automatic logic [11:0] med3(input logic [11:0] a,
                                         input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] lo;
        logic [11:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo) begin
            med3 = lo;
        end else if (c >= hi) begin
            med3 = hi;
        end else begin
            med3 = c;
        end
    endfunction

    // Median of the newest sample and the two before it; after loss of history
    // the first sample fills all three slots.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            hist0_r     <= 12'd0;
            hist1_r     <= 12'd0;
            med_empty_r <= 1'b1;
            m_valid_r   <= 1'b0;
            m_data_r    <= 12'd0;
        end else begin
            m_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                hist0_r <= s1_data_r;
                if (med_empty_r) begin
                    hist1_r     <= s1_data_r;
                    m_data_r    <= s1_data_r;
                    med_empty_r <= 1'b0;
                end else begin
                    hist1_r  <= hist0_r;
                    m_data_r <= med3(s1_data_r, hist0_r, hist1_r);
                end
            end else if (timeout_s) begin
                med_empty_r <= 1'b1;
            end else begin
                med_empty_r <= med_empty_r;
            end
        end
    end

    assign a_valid_s = m_valid_r;
    assign a_data_s  = m_data_r;
`else
    assign a_valid_s = s1_valid_r;
    assign a_data_s  = s1_data_r;
`endif

    // Running-sum and window-state update for the sample entering the averager.
    always_comb begin
        sum_next   = sum_r;
        state_next = state_r;
        if (a_valid_s) begin
            state_next = S_TRACK;
            if (state_r == S_EMPTY) begin
                sum_next = SUM_W'(a_data_s) << LOG2_WIN;
            end else begin
                sum_next = sum_r - SUM_W'(buf_r[wptr_r]) + SUM_W'(a_data_s);
            end
        end else if (timeout_s) begin
            state_next = S_EMPTY;
        end else begin
            state_next = state_r;
        end
    end

    assign avg_next = sum_next[SUM_W-1:LOG2_WIN];

    // Alarm hysteresis applied to the average about to be published.
    always_comb begin
        near_next = near;
        if (avg_next < NEAR_V) begin
            near_next = 1'b1;
        end else if (avg_next >= REL_V) begin
            near_next = 1'b0;
        end else begin
            near_next = near;
        end
    end

    // Window state register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_r <= S_EMPTY;
            sum_r   <= '0;
        end else begin
            state_r <= state_next;
            sum_r   <= sum_next;
        end
    end

    // Sample window: preload every slot when empty, else overwrite the oldest.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < WIN; i++) begin
                buf_r[i] <= 12'd0;
            end
            wptr_r <= '0;
        end else if (a_valid_s) begin
            if (state_r == S_EMPTY) begin
                for (int i = 0; i < WIN; i++) begin
                    buf_r[i] <= a_data_s;
                end
            end else begin
                buf_r[wptr_r] <= a_data_s;
                wptr_r        <= wptr_r + LOG2_WIN'(1);
            end
        end
    end

    // Published outputs: average strobe, alarm level and echo-loss level.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            avg_out   <= 12'd0;
            avg_valid <= 1'b0;
            near      <= 1'b0;
            no_echo   <= 1'b1;
        end else if (a_valid_s) begin
            avg_out   <= avg_next;
            avg_valid <= 1'b1;
            near      <= near_next;
            no_echo   <= 1'b0;
        end else if (timeout_s) begin
            avg_valid <= 1'b0;
            near      <= 1'b0;
            no_echo   <= 1'b1;
        end else begin
            avg_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dist_filter.sv
// Bench for dist_filter: a queue-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_dist_filter;
    localparam int WIN  = 4;
    localparam int MINV = 2;
    localparam int MAXV = 400;
    localparam int NEAR = 20;
    localparam int HYST = 5;
    localparam int TMO  = 1000;
`ifdef DIST_MEDIAN3_EN
    localparam int LAT  = 3;
`else
    localparam int LAT  = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [11:0] dist_in = 12'd0;
    logic        dist_valid = 1'b0;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic        near;
    logic        no_echo;
    logic        reject;

    int checks = 0;
    int errors = 0;

    dist_filter #(
        .LOG2_WIN(2), .MIN_CM(MINV), .MAX_CM(MAXV),
        .NEAR_CM(NEAR), .HYST_CM(HYST), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset_p(reset_p), .dist_in(dist_in), .dist_valid(dist_valid),
        .avg_out(avg_out), .avg_valid(avg_valid), .near(near),
        .no_echo(no_echo), .reject(reject)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { int val; int due; } pend_t;
    int    m_edge = 0, m_idle = 0, m_avg = 0, m_near = 0, m_noecho = 1, m_rej = 0, m_av = 0;
    bit    m_empty = 1'b1, m_med_empty = 1'b1;
    int    m_win[$];
    int    m_hist[$];
    pend_t m_pend[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_edge = 0; m_idle = 0; m_avg = 0; m_near = 0; m_noecho = 1;
        m_rej = 0; m_av = 0; m_empty = 1'b1; m_med_empty = 1'b1;
        m_win.delete(); m_hist.delete(); m_pend.delete();
    endtask

    function automatic int med3(input int a, input int b, input int c);
        int lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction

    // Advance the model by one clock edge with the inputs sampled at that edge.
    task automatic model_edge(input bit v, input int d);
        int    f, s;
        pend_t p;
        m_edge++;
        m_rej = 0;
        m_av  = 0;
        if (m_pend.size() > 0 && m_pend[0].due == m_edge) begin
            p = m_pend.pop_front();
            m_avg = p.val; m_av = 1; m_noecho = 0;
            if (p.val < NEAR) m_near = 1;
            else if (p.val >= NEAR + HYST) m_near = 0;
        end
        if (v && d >= MINV && d <= MAXV) begin
            m_idle = 0;
            f = d;
`ifdef DIST_MEDIAN3_EN
            if (m_med_empty) begin
                m_hist.delete();
                repeat (3) m_hist.push_back(d);
                m_med_empty = 1'b0;
            end else begin
                m_hist.push_back(d);
                void'(m_hist.pop_front());
            end
            f = med3(m_hist[0], m_hist[1], m_hist[2]);
`endif
            if (m_empty) begin
                m_win.delete();
                repeat (WIN) m_win.push_back(f);
                m_empty = 1'b0;
            end else begin
                m_win.push_back(f);
                void'(m_win.pop_front());
            end
            s = 0;
            foreach (m_win[i]) s += m_win[i];
            p.val = s / WIN;
            p.due = m_edge + LAT - 1;
            m_pend.push_back(p);
        end else begin
            if (v) m_rej = 1;
            m_idle++;
            if (m_idle >= TMO) begin
                m_noecho = 1; m_near = 0; m_empty = 1'b1; m_med_empty = 1'b1;
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("avg_valid", int'(avg_valid), m_av);
        chk("avg_out", int'(avg_out), m_avg);
        chk("near", int'(near), m_near);
        chk("no_echo", int'(no_echo), m_noecho);
        chk("reject", int'(reject), m_rej);
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input int d);
        dist_valid = v;
        dist_in    = 12'(d);
        @(posedge clk);
        model_edge(v, d);
        #1;
    endtask

    task automatic feed(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, d);
            step(1'b0, 0);
        end
    endtask

    int exp60[4] = '{90, 80, 70, 60};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_avg_out", int'(avg_out), 0);
        chk("rst_no_echo", int'(no_echo), 1);
        chk("rst_avg_valid", int'(avg_valid), 0);
        reset_p = 1'b0;

`ifdef DIST_MEDIAN3_EN
        step(1'b1, 100);
        step(1'b1, 100);
        step(1'b1, 300);
        step(1'b0, 0);
        chk("med_second_valid", int'(avg_valid), 1);
        step(1'b0, 0);
        chk("med_third_valid", int'(avg_valid), 1);
        chk("med_third_out", int'(avg_out), 100);
        repeat (3) step(1'b0, 0);
`else
        // first sample preloads the window
        step(1'b1, 100);
        chk("first_early", int'(avg_valid), 0);
        step(1'b0, 0);
        chk("first_valid", int'(avg_valid), 1);
        chk("first_out", int'(avg_out), 100);
        chk("first_no_echo", int'(no_echo), 0);
        chk("first_near", int'(near), 0);

        // back-to-back strobes of 60
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 60);
            if (i >= 1) begin
                chk("seq60_valid", int'(avg_valid), 1);
                chk("seq60_out", int'(avg_out), exp60[i-1]);
            end
        end

        // out-of-range samples including the edges just outside the window
        step(1'b1, 0);
        chk("rej0", int'(reject), 1);
        chk("rej0_noavg", int'(avg_valid), 0);
        step(1'b1, 500);
        chk("rej500", int'(reject), 1);
        step(1'b1, 1);
        chk("rej1", int'(reject), 1);
        step(1'b1, 401);
        chk("rej401", int'(reject), 1);
        step(1'b0, 0);
        chk("rej_clear", int'(reject), 0);
        chk("rej_hold_avg", int'(avg_out), 60);

        // alarm hysteresis
        feed(30, 4);
        chk("avg30", int'(avg_out), 30);
        chk("near30", int'(near), 0);
        feed(19, 4);
        chk("avg19", int'(avg_out), 19);
        chk("near19", int'(near), 1);
        feed(22, 4);
        chk("avg22", int'(avg_out), 22);
        chk("near22", int'(near), 1);
        feed(25, 3);
        chk("avg24", int'(avg_out), 24);
        chk("near24", int'(near), 1);
        feed(25, 1);
        chk("avg25", int'(avg_out), 25);
        chk("near25", int'(near), 0);

        // boundary-accepted samples, ending with the alarm set
        feed(400, 1);
        chk("avg400", int'(avg_out), 118);
        feed(2, 4);
        chk("avg2", int'(avg_out), 2);
        chk("near2", int'(near), 1);

        // watchdog expiry; a reject midway must not feed it
        for (int i = 0; i < 1010; i++) begin
            step(i == 500, 0);
        end
        chk("tmo_no_echo", int'(no_echo), 1);
        chk("tmo_near", int'(near), 0);
        chk("tmo_hold_avg", int'(avg_out), 2);
        step(1'b1, 50);
        chk("tmo_pending", int'(no_echo), 1);
        step(1'b0, 0);
        chk("tmo_preload", int'(avg_out), 50);
        chk("tmo_recover", int'(no_echo), 0);

        // accepted sample exactly in the expiry cycle
        repeat (998) step(1'b0, 0);
        step(1'b1, 70);
        chk("race_no_echo", int'(no_echo), 0);
        step(1'b0, 0);
        chk("race_avg", int'(avg_out), 55);

        // reset with a sample in flight
        step(1'b1, 200);
        reset_p = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 0);
            chk("rst_flush", int'(avg_valid), 0);
        end
        chk("rst_flush_avg", int'(avg_out), 0);
        feed(80, 1);
        chk("post_rst_avg", int'(avg_out), 80);
`endif
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
